mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl_if.sv | 47 ++++
 rtl/mem_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: ROB index width, FSM encoding,
// access-width decode and the IO-space address test.
package mem_ctrl_pkg;

    localparam int ROBBW = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_RD = 3'd1,
        ST_LS_RD = 3'd2,
        ST_LS_WR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // addr[17:16] selects the UART-backed IO window
    localparam logic [1:0] IO_SPACE = 2'b11;

    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_space(input logic [1:0] seg);
        return seg == IO_SPACE;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the fetch unit, the load/store buffer, the byte-wide RAM
// and the memory controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic             if_req_flag;
    logic [31:0]      if_req_addr;
    logic             if_done_flag;
    logic [31:0]      if_data;

    logic             lsb_req_flag;
    logic [1:0]       lsb_req_width;
    logic             lsb_req_type;
    logic [31:0]      lsb_req_addr;
    logic [31:0]      lsb_req_data;
    logic [ROBBW-1:0] lsb_req_rob_id;
    logic             lsb_done_flag;

    logic             ld_cdb_flag;
    logic [ROBBW-1:0] ld_cdb_rob_id;
    logic [31:0]      ld_cdb_val;

    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;
    logic             io_buffer_full;

    modport slave (
        input  if_req_flag, if_req_addr,
        input  lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_addr, lsb_req_data, lsb_req_rob_id,
        input  mem_din, io_buffer_full,
        output if_done_flag, if_data, lsb_done_flag,
        output ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req_flag, if_req_addr,
        output lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_addr, lsb_req_data, lsb_req_rob_id,
        output mem_din, io_buffer_full,
        input  if_done_flag, if_data, lsb_done_flag,
        input  ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSB traffic
// onto a single 8-bit RAM port with one-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      jump_wrong,
    mem_ctrl_if.slave bus
);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [2:0]       r_len;
    logic [31:0]      r_mem_a;
    logic [7:0]       r_mem_dout;
    logic             r_mem_wr;
    logic [23:0]      r_wdata;
    logic             r_is_io;
    logic [31:0]      r_data;
    logic [ROBBW-1:0] r_rob_id;
    logic             r_last_lsb;
    logic             r_frozen;
    logic [7:0]       r_din_skid;
    logic             r_if_done;
    logic             r_lsb_done;
    logic             r_cdb_flag;
    logic [31:0]      r_if_data;
    logic [31:0]      r_cdb_val;
    logic [ROBBW-1:0] r_cdb_rob_id;

    logic             w_if_req;
    logic             w_lsb_req;
    logic             w_grant_lsb;
    logic             w_io_stall;
    logic [7:0]       w_byte;
    logic [2:0]       w_idx;
    logic [31:0]      w_asm;

    // a mispredict squashes speculative fetches and loads, never stores
    assign w_if_req    = bus.if_req_flag && !jump_wrong;
    assign w_lsb_req   = bus.lsb_req_flag && (!jump_wrong || bus.lsb_req_type);
    assign w_grant_lsb = w_lsb_req && (!w_if_req || !r_last_lsb);
    assign w_io_stall  = r_is_io && bus.io_buffer_full;

    // After a freeze the byte that was in flight sits in the skid register,
    // while mem_din already reflects the held address.
    assign w_byte = r_frozen ? r_din_skid : bus.mem_din;
    assign w_idx  = r_cnt - 3'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_asm
            assign w_asm[8*gi +: 8] = (r_cnt != 3'd0 && w_idx == 3'(gi)) ? w_byte : r_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_len        <= 3'd0;
            r_mem_a      <= 32'd0;
            r_mem_dout   <= 8'd0;
            r_mem_wr     <= 1'b0;
            r_wdata      <= 24'd0;
            r_is_io      <= 1'b0;
            r_data       <= 32'd0;
            r_rob_id     <= '0;
            r_last_lsb   <= 1'b0;
            r_frozen     <= 1'b0;
            r_din_skid   <= 8'd0;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_cdb_flag   <= 1'b0;
            r_if_data    <= 32'd0;
            r_cdb_val    <= 32'd0;
            r_cdb_rob_id <= '0;
        end else if (!rdy) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            r_cdb_flag <= 1'b0;
            if (!r_frozen)
                r_din_skid <= bus.mem_din;
            r_frozen <= 1'b1;
        end else begin
            r_frozen   <= 1'b0;
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            r_cdb_flag <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_req || w_lsb_req) begin
                        r_last_lsb <= w_grant_lsb;
                        r_cnt      <= 3'd0;
                        r_data     <= 32'd0;
                        if (w_grant_lsb) begin
                            r_mem_a  <= bus.lsb_req_addr;
                            r_len    <= byte_count(bus.lsb_req_width);
                            r_rob_id <= bus.lsb_req_rob_id;
                            r_is_io  <= is_io_space(bus.lsb_req_addr[17:16]);
                            if (bus.lsb_req_type) begin
                                r_state    <= ST_LS_WR;
                                r_mem_wr   <= 1'b1;
                                r_mem_dout <= bus.lsb_req_data[7:0];
                                r_wdata    <= bus.lsb_req_data[31:8];
                            end else begin
                                r_state <= ST_LS_RD;
                            end
                        end else begin
                            r_mem_a <= bus.if_req_addr;
                            r_len   <= 3'd4;
                            r_is_io <= 1'b0;
                            r_state <= ST_IF_RD;
                        end
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (jump_wrong) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_data <= w_asm;
                        if (r_cnt == r_len) begin
                            r_state <= ST_DONE;
                            if (r_state == ST_IF_RD) begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_asm;
                            end else begin
                                r_lsb_done   <= 1'b1;
                                r_cdb_flag   <= 1'b1;
                                r_cdb_val    <= w_asm;
                                r_cdb_rob_id <= r_rob_id;
                            end
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_mem_a <= r_mem_a + 32'd1;
                        end
                    end
                end
                ST_LS_WR: begin
                    if (!w_io_stall) begin
                        if (r_cnt == r_len - 3'd1) begin
                            r_mem_wr   <= 1'b0;
                            r_state    <= ST_DONE;
                            r_lsb_done <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_mem_a + 32'd1;
                            r_mem_dout <= r_wdata[7:0];
                            r_wdata    <= {8'h00, r_wdata[23:8]};
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a         = r_mem_a;
    assign bus.mem_dout      = r_mem_dout;
    assign bus.mem_wr        = r_mem_wr && rdy && !w_io_stall;
    assign bus.if_done_flag  = r_if_done;
    assign bus.if_data       = r_if_data;
    assign bus.lsb_done_flag = r_lsb_done;
    assign bus.ld_cdb_flag   = r_cdb_flag;
    assign bus.ld_cdb_val    = r_cdb_val;
    assign bus.ld_cdb_rob_id = r_cdb_rob_id;

endmodule
